// File: rtl/apb_bridge_pkg.sv
// -----------------------------------------------------------------------------
// apb_bridge_pkg
// Shared definitions for the AHB2APB bridge transfer controller:
//   - apb_state_e  : APB sequencing states (IDLE / SETUP / ACCESS)
//   - SLVn_BASE/LIMIT : inclusive address windows of the three peripherals
//   - PSEL_*       : one-hot peripheral select codes
//   - REQ_W        : width of a queued request {write, addr[31:0], wdata[31:0]}
//   - apb_decode() : maps a byte address to {valid, sel[2:0]}
// -----------------------------------------------------------------------------
package apb_bridge_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETUP  = 2'd1,
      ST_ACCESS = 2'd2
   } apb_state_e;

   localparam logic [31:0] SLV0_BASE  = 32'h8000_0000;
   localparam logic [31:0] SLV0_LIMIT = 32'h83FF_FFFF;
   localparam logic [31:0] SLV1_BASE  = 32'h8400_0000;
   localparam logic [31:0] SLV1_LIMIT = 32'h87FF_FFFF;
   localparam logic [31:0] SLV2_BASE  = 32'h8800_0000;
   localparam logic [31:0] SLV2_LIMIT = 32'h8BFF_FFFF;

   localparam logic [2:0] PSEL_NONE = 3'b000;
   localparam logic [2:0] PSEL_S0   = 3'b001;
   localparam logic [2:0] PSEL_S1   = 3'b010;
   localparam logic [2:0] PSEL_S2   = 3'b100;

   localparam int REQ_W = 65;

   // Returns {valid, sel}; sel is PSEL_NONE whenever valid is 0.
   function automatic logic [3:0] apb_decode(input logic [31:0] addr);
      logic [3:0] res;
      res = {1'b0, PSEL_NONE};
      if (addr >= SLV0_BASE && addr <= SLV0_LIMIT) begin
         res = {1'b1, PSEL_S0};
      end else if (addr >= SLV1_BASE && addr <= SLV1_LIMIT) begin
         res = {1'b1, PSEL_S1};
      end else if (addr >= SLV2_BASE && addr <= SLV2_LIMIT) begin
         res = {1'b1, PSEL_S2};
      end
      return res;
   endfunction

endpackage

// File: rtl/apb_req_fifo.sv
// -----------------------------------------------------------------------------
// apb_req_fifo
// Synchronous request FIFO, DEPTH entries of WIDTH bits, no read bypass.
// Ports:
//   clk, rst        : clock, asynchronous active-high reset (empties FIFO)
//   push, wr_data   : write request; ignored while full
//   pop, rd_data    : remove head; rd_data always shows the current head
//   full, empty     : occupancy flags
// -----------------------------------------------------------------------------
module apb_req_fifo #(
   parameter int DEPTH = 2,
   parameter int WIDTH = 65
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             pop,
   output logic [WIDTH-1:0] rd_data,
   output logic             full,
   output logic             empty
);

   localparam int PW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [PW:0]      count_q, count_d;
   logic             do_push, do_pop;

   assign full    = (count_q == (PW+1)'(DEPTH));
   assign empty   = (count_q == '0);
   assign rd_data = mem_q[rd_ptr_q];

   always_comb begin
      do_push  = push && !full;
      do_pop   = pop && !empty;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      // DEPTH is a power of two, so pointer overflow is the modulo wrap.
      if (do_push) begin
         wr_ptr_d = wr_ptr_q + PW'(1);
      end
      if (do_pop) begin
         rd_ptr_d = rd_ptr_q + PW'(1);
      end
      if (do_push && !do_pop) begin
         count_d = count_q + (PW+1)'(1);
      end else if (!do_push && do_pop) begin
         count_d = count_q - (PW+1)'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage carries data only; occupancy is tracked by the pointers above.
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem_q[wr_ptr_q] <= wr_data;
      end
   end

endmodule

// File: rtl/apb_transfer_controller.sv
// -----------------------------------------------------------------------------
// apb_transfer_controller
// Queues AHB-side requests, decodes them to one of three APB peripherals and
// runs each through IDLE -> SETUP -> ACCESS with wait-state and timeout
// handling. Responses are single-cycle pulses without backpressure.
// Ports:
//   Hclk, Hreset                 : clock, asynchronous active-high reset
//   req_valid/req_ready          : request handshake (ready = FIFO not full)
//   req_write/req_addr/req_wdata : request payload
//   Pselx/Penable/Pwrite/Paddr/Pwdata : APB master outputs (registered)
//   Prdata/Pready                : APB slave returns
//   rsp_valid/rsp_rdata/rsp_err  : response pulse, read data, error flag
//   busy                         : transfer in progress or requests queued
// -----------------------------------------------------------------------------
module apb_transfer_controller #(
   parameter int DEPTH   = 2,
   parameter int TIMEOUT = 16
) (
   input  logic        Hclk,
   input  logic        Hreset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_write,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        Pwrite,
   output logic        Penable,
   output logic [2:0]  Pselx,
   output logic [31:0] Paddr,
   output logic [31:0] Pwdata,
   input  logic [31:0] Prdata,
   input  logic        Pready,
   output logic        rsp_valid,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err,
   output logic        busy
);

   import apb_bridge_pkg::*;

   localparam int            CW       = $clog2(TIMEOUT);
   localparam logic [CW-1:0] WAIT_MAX = CW'(TIMEOUT - 1);

   apb_state_e        state_q, state_d;
   logic [2:0]        psel_q, psel_d;
   logic              penable_q, penable_d;
   logic              pwrite_q, pwrite_d;
   logic [31:0]       paddr_q, paddr_d;
   logic [31:0]       pwdata_q, pwdata_d;
   logic              rsp_valid_q, rsp_valid_d;
   logic [31:0]       rsp_rdata_q, rsp_rdata_d;
   logic              rsp_err_q, rsp_err_d;
   logic [CW-1:0]     wait_q, wait_d;

   logic [REQ_W-1:0]  fifo_head;
   logic              fifo_full, fifo_empty, fifo_pop;
   logic              head_write;
   logic [31:0]       head_addr, head_wdata;
   logic [3:0]        head_dec;
   logic              head_ok;
   logic              load_head;

   apb_req_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (REQ_W)
   ) u_fifo (
      .clk     (Hclk),
      .rst     (Hreset),
      .push    (req_valid),
      .wr_data ({req_write, req_addr, req_wdata}),
      .pop     (fifo_pop),
      .rd_data (fifo_head),
      .full    (fifo_full),
      .empty   (fifo_empty)
   );

   assign head_write = fifo_head[64];
   assign head_addr  = fifo_head[63:32];
   assign head_wdata = fifo_head[31:0];
   assign head_dec   = apb_decode(head_addr);
   assign head_ok    = !fifo_empty && head_dec[3];

   always_comb begin
      state_d     = state_q;
      psel_d      = psel_q;
      penable_d   = penable_q;
      pwrite_d    = pwrite_q;
      paddr_d     = paddr_q;
      pwdata_d    = pwdata_q;
      wait_d      = wait_q;
      rsp_valid_d = 1'b0;
      rsp_rdata_d = '0;
      rsp_err_d   = 1'b0;
      fifo_pop    = 1'b0;
      load_head   = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (head_ok) begin
               load_head = 1'b1;
            end else if (!fifo_empty) begin
               // Undecodable request: consume it and answer with an error,
               // never touching the APB bus.
               fifo_pop    = 1'b1;
               rsp_valid_d = 1'b1;
               rsp_err_d   = 1'b1;
            end
         end
         ST_SETUP: begin
            state_d   = ST_ACCESS;
            penable_d = 1'b1;
            wait_d    = '0;
         end
         ST_ACCESS: begin
            if (Pready) begin
               rsp_valid_d = 1'b1;
               rsp_rdata_d = pwrite_q ? 32'h0 : Prdata;
               // Chain straight into the next SETUP only for a decodable
               // head; an error head is answered from IDLE.
               if (head_ok) begin
                  load_head = 1'b1;
               end else begin
                  state_d   = ST_IDLE;
                  psel_d    = PSEL_NONE;
                  penable_d = 1'b0;
               end
            end else if (wait_q == WAIT_MAX) begin
               state_d     = ST_IDLE;
               psel_d      = PSEL_NONE;
               penable_d   = 1'b0;
               rsp_valid_d = 1'b1;
               rsp_err_d   = 1'b1;
            end else begin
               wait_d = wait_q + CW'(1);
            end
         end
         default: begin
            state_d   = ST_IDLE;
            psel_d    = PSEL_NONE;
            penable_d = 1'b0;
         end
      endcase

      if (load_head) begin
         fifo_pop  = 1'b1;
         state_d   = ST_SETUP;
         psel_d    = head_dec[2:0];
         penable_d = 1'b0;
         pwrite_d  = head_write;
         paddr_d   = head_addr;
         pwdata_d  = head_wdata;
      end
   end

   always_ff @(posedge Hclk or posedge Hreset) begin
      if (Hreset) begin
         state_q     <= ST_IDLE;
         psel_q      <= PSEL_NONE;
         penable_q   <= 1'b0;
         pwrite_q    <= 1'b0;
         paddr_q     <= '0;
         pwdata_q    <= '0;
         wait_q      <= '0;
         rsp_valid_q <= 1'b0;
         rsp_rdata_q <= '0;
         rsp_err_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         psel_q      <= psel_d;
         penable_q   <= penable_d;
         pwrite_q    <= pwrite_d;
         paddr_q     <= paddr_d;
         pwdata_q    <= pwdata_d;
         wait_q      <= wait_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_rdata_q <= rsp_rdata_d;
         rsp_err_q   <= rsp_err_d;
      end
   end

   assign req_ready = !fifo_full;
   assign Pselx     = psel_q;
   assign Penable   = penable_q;
   assign Pwrite    = pwrite_q;
   assign Paddr     = paddr_q;
   assign Pwdata    = pwdata_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_rdata = rsp_rdata_q;
   assign rsp_err   = rsp_err_q;
   assign busy      = (state_q != ST_IDLE) || !fifo_empty;

endmodule

// File: tb/tb_apb_transfer_controller.sv
// -----------------------------------------------------------------------------
// tb_apb_transfer_controller
// Directed bench for apb_transfer_controller with a transaction-level model:
// each accepted request is scheduled onto a timeline (setup cycle, access
// window, response cycle) and every cycle's outputs are compared against it.
// -----------------------------------------------------------------------------
module tb_apb_transfer_controller;

   localparam int DEPTH   = 2;
   localparam int TIMEOUT = 16;

   typedef struct {
      logic        write;
      logic [31:0] addr;
      logic [31:0] wdata;
      int          ws;      // Pready-low cycles the slave inserts
      logic [31:0] rdata;   // data the slave returns
   } req_t;

   typedef struct {
      int          due;
      logic        err;
      logic [31:0] rdata;
   } rsp_t;

   logic        Hclk, Hreset;
   logic        req_valid, req_ready, req_write;
   logic [31:0] req_addr, req_wdata;
   logic        Pwrite, Penable;
   logic [2:0]  Pselx;
   logic [31:0] Paddr, Pwdata, Prdata;
   logic        Pready;
   logic        rsp_valid, rsp_err, busy;
   logic [31:0] rsp_rdata;

   apb_transfer_controller #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
      .Hclk(Hclk), .Hreset(Hreset),
      .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
      .req_addr(req_addr), .req_wdata(req_wdata),
      .Pwrite(Pwrite), .Penable(Penable), .Pselx(Pselx), .Paddr(Paddr),
      .Pwdata(Pwdata), .Prdata(Prdata), .Pready(Pready),
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
      .busy(busy)
   );

   initial Hclk = 1'b0;
   always #5 Hclk = ~Hclk;

   int   checks = 0;
   int   errors = 0;
   int   cyc    = 0;

   // model state
   req_t        mq[$];
   rsp_t        rq[$];
   logic        m_active;
   req_t        m_cur;
   int          m_start, m_end;
   logic        m_tmo;
   logic [2:0]  m_sel;
   logic        m_pwrite;
   logic [31:0] m_paddr, m_pwdata;
   logic        last_acc;
   int          last_acc_cyc;

   // observations for the hand-computed expectations
   int          obs_rsp_cyc[$];
   logic        obs_rsp_err[$];
   logic [31:0] obs_rsp_rdata[$];
   int          obs_setup_cyc[$];
   logic [2:0]  obs_setup_sel[$];
   int          obs_acc_cnt;
   logic        saw_full, saw_psel;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s cycle %0d: got 0x%0h expected 0x%0h", name, cyc, act, exp);
      end
   endtask

   task automatic bound_fail(input string name);
      checks++;
      errors++;
      $display("FAIL %s cycle %0d: wait bound expired", name, cyc);
   endtask

   // Address map as arithmetic: 64 MiB windows starting at 0x8000_0000.
   function automatic logic [3:0] m_decode(input logic [31:0] a);
      logic [31:0] idx;
      logic [2:0]  s;
      if (a >= 32'h8000_0000 && a < 32'h8C00_0000) begin
         idx = (a - 32'h8000_0000) / 32'h0400_0000;
         s   = 3'b001 << idx;
         return {1'b1, s};
      end
      return 4'b0000;
   endfunction

   function automatic req_t mk(input logic w, input logic [31:0] a, input logic [31:0] d,
                               input int ws, input logic [31:0] rd);
      req_t r;
      r.write = w; r.addr = a; r.wdata = d; r.ws = ws; r.rdata = rd;
      return r;
   endfunction

   task automatic model_reset();
      mq.delete();
      rq.delete();
      m_active = 1'b0;
      m_cur    = mk(1'b0, 32'h0, 32'h0, 0, 32'h0);
      m_start  = 0;
      m_end    = -1;
      m_tmo    = 1'b0;
      m_sel    = 3'b000;
      m_pwrite = 1'b0;
      m_paddr  = 32'h0;
      m_pwdata = 32'h0;
   endtask

   task automatic clear_obs();
      obs_rsp_cyc.delete();
      obs_rsp_err.delete();
      obs_rsp_rdata.delete();
      obs_setup_cyc.delete();
      obs_setup_sel.delete();
      obs_acc_cnt = 0;
      saw_full    = 1'b0;
      saw_psel    = 1'b0;
   endtask

   // One clock cycle: drive, compare mid-cycle, then advance the model at the edge.
   task automatic cycle(input logic v, input req_t r);
      logic       in_win, in_acc, take;
      logic [3:0] hd;
      req_t       h;
      rsp_t       p;
      req_valid = v;
      req_write = r.write;
      req_addr  = r.addr;
      req_wdata = r.wdata;
      in_win = m_active && (cyc >= m_start) && (cyc <= m_end);
      in_acc = m_active && (cyc >  m_start) && (cyc <= m_end);
      if (in_acc) begin
         Pready = ((cyc - m_start - 1) >= m_cur.ws);
         Prdata = m_cur.rdata;
      end else begin
         Pready = 1'($urandom_range(0, 1));
         Prdata = $urandom;
      end

      @(negedge Hclk);
      chk("Pselx",     {29'h0, Pselx},   {29'h0, (in_win ? m_sel : 3'b000)});
      chk("Penable",   {31'h0, Penable}, {31'h0, in_acc});
      chk("Pwrite",    {31'h0, Pwrite},  {31'h0, m_pwrite});
      chk("Paddr",     Paddr,            m_paddr);
      chk("Pwdata",    Pwdata,           m_pwdata);
      chk("req_ready", {31'h0, req_ready}, {31'h0, (mq.size() < DEPTH)});
      chk("busy",      {31'h0, busy},    {31'h0, (in_win || mq.size() > 0)});
      if (rq.size() > 0 && rq[0].due == cyc) begin
         p = rq.pop_front();
         chk("rsp_valid", {31'h0, rsp_valid}, 32'h1);
         chk("rsp_err",   {31'h0, rsp_err},   {31'h0, p.err});
         chk("rsp_rdata", rsp_rdata,          p.rdata);
      end else begin
         chk("rsp_valid", {31'h0, rsp_valid}, 32'h0);
      end
      if (rsp_valid) begin
         obs_rsp_cyc.push_back(cyc);
         obs_rsp_err.push_back(rsp_err);
         obs_rsp_rdata.push_back(rsp_rdata);
      end
      if (Pselx != 3'b000) saw_psel = 1'b1;
      if (Pselx != 3'b000 && !Penable) begin
         obs_setup_cyc.push_back(cyc);
         obs_setup_sel.push_back(Pselx);
      end
      if (Penable) obs_acc_cnt++;
      if (!req_ready) saw_full = 1'b1;
      last_acc = v && (mq.size() < DEPTH);

      @(posedge Hclk);
      if (m_active && cyc == m_end) begin
         p.due   = cyc + 1;
         p.err   = m_tmo;
         p.rdata = (!m_tmo && !m_cur.write) ? m_cur.rdata : 32'h0;
         rq.push_back(p);
      end
      take = 1'b0;
      if (mq.size() > 0) begin
         hd = m_decode(mq[0].addr);
         if (!(m_active && cyc <= m_end)) take = 1'b1;
         else if (cyc == m_end && !m_tmo && hd[3]) take = 1'b1;
      end
      if (m_active && cyc == m_end) m_active = 1'b0;
      if (take) begin
         h  = mq.pop_front();
         hd = m_decode(h.addr);
         if (hd[3]) begin
            m_active = 1'b1;
            m_cur    = h;
            m_start  = cyc + 1;
            m_tmo    = (h.ws >= TIMEOUT);
            m_end    = m_start + (m_tmo ? TIMEOUT : h.ws + 1);
            m_sel    = hd[2:0];
            m_pwrite = h.write;
            m_paddr  = h.addr;
            m_pwdata = h.wdata;
         end else begin
            p.due = cyc + 1; p.err = 1'b1; p.rdata = 32'h0;
            rq.push_back(p);
         end
      end
      if (last_acc) begin
         mq.push_back(r);
         last_acc_cyc = cyc;
      end
      cyc++;
      #1;
   endtask

   task automatic idle();
      cycle(1'b0, mk(1'($urandom_range(0, 1)), $urandom, $urandom, 0, 32'h0));
   endtask

   task automatic send(input req_t r);
      int n;
      n = 0;
      last_acc = 1'b0;
      while (!last_acc && n < 50) begin
         cycle(1'b1, r);
         n++;
      end
      if (!last_acc) bound_fail("send_accept");
   endtask

   task automatic drain();
      int n;
      n = 0;
      while ((m_active || mq.size() > 0 || rq.size() > 0) && n < 200) begin
         idle();
         n++;
      end
      if (n >= 200) bound_fail("drain");
      idle();
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int   n0, n;
      req_t r;

      Hreset = 1'b1; req_valid = 1'b0; req_write = 1'b0;
      req_addr = 32'h0; req_wdata = 32'h0; Prdata = 32'h0; Pready = 1'b1;
      model_reset();
      clear_obs();
      repeat (3) @(posedge Hclk);
      @(negedge Hclk);
      chk("rst_Pselx",     {29'h0, Pselx},     32'h0);
      chk("rst_Penable",   {31'h0, Penable},   32'h0);
      chk("rst_Pwrite",    {31'h0, Pwrite},    32'h0);
      chk("rst_Paddr",     Paddr,              32'h0);
      chk("rst_Pwdata",    Pwdata,             32'h0);
      chk("rst_rsp_valid", {31'h0, rsp_valid}, 32'h0);
      chk("rst_rsp_rdata", rsp_rdata,          32'h0);
      chk("rst_rsp_err",   {31'h0, rsp_err},   32'h0);
      chk("rst_busy",      {31'h0, busy},      32'h0);
      Hreset = 1'b0;
      @(posedge Hclk);
      #1;
      chk("rst_req_ready", {31'h0, req_ready}, 32'h1);

      // zero-wait write to slave 0
      clear_obs();
      send(mk(1'b1, 32'h8000_0010, 32'hDEAD_BEEF, 0, 32'h0));
      n0 = last_acc_cyc;
      drain();
      chk("t1_nsetup", obs_setup_cyc.size(), 1);
      if (obs_setup_cyc.size() > 0) begin
         chk("t1_setup_cyc", obs_setup_cyc[0], n0 + 2);
         chk("t1_setup_sel", {29'h0, obs_setup_sel[0]}, 32'h1);
      end
      chk("t1_access_cnt", obs_acc_cnt, 1);
      chk("t1_nrsp", obs_rsp_cyc.size(), 1);
      if (obs_rsp_cyc.size() > 0) begin
         chk("t1_rsp_cyc", obs_rsp_cyc[0], n0 + 4);
         chk("t1_rsp_err", {31'h0, obs_rsp_err[0]}, 32'h0);
      end

      // read with three wait states on slave 1
      clear_obs();
      send(mk(1'b0, 32'h8400_0004, 32'h0, 3, 32'h1234_5678));
      n0 = last_acc_cyc;
      drain();
      chk("t2_access_cnt", obs_acc_cnt, 4);
      chk("t2_nrsp", obs_rsp_cyc.size(), 1);
      if (obs_rsp_cyc.size() > 0) begin
         chk("t2_rsp_cyc",   obs_rsp_cyc[0], n0 + 7);
         chk("t2_rsp_rdata", obs_rsp_rdata[0], 32'h1234_5678);
      end

      // decode error
      clear_obs();
      send(mk(1'b0, 32'h9000_0000, 32'h0, 0, 32'h5555_AAAA));
      n0 = last_acc_cyc;
      drain();
      chk("t3_no_psel", {31'h0, saw_psel}, 32'h0);
      chk("t3_nrsp", obs_rsp_cyc.size(), 1);
      if (obs_rsp_cyc.size() > 0) begin
         chk("t3_rsp_cyc", obs_rsp_cyc[0], n0 + 2);
         chk("t3_rsp_err", {31'h0, obs_rsp_err[0]}, 32'h1);
      end

      // timeout: slave never ready
      clear_obs();
      send(mk(1'b0, 32'h8800_0008, 32'h0, 1000, 32'hFFFF_0000));
      n0 = last_acc_cyc;
      drain();
      chk("t4_access_cnt", obs_acc_cnt, 16);
      chk("t4_nrsp", obs_rsp_cyc.size(), 1);
      if (obs_rsp_cyc.size() > 0) begin
         chk("t4_rsp_cyc",   obs_rsp_cyc[0], n0 + 19);
         chk("t4_rsp_err",   {31'h0, obs_rsp_err[0]}, 32'h1);
         chk("t4_rsp_rdata", obs_rsp_rdata[0], 32'h0);
      end
      chk("t4_busy_after", {31'h0, busy}, 32'h0);

      // three back-to-back writes, one per slave
      clear_obs();
      send(mk(1'b1, 32'h8000_0100, 32'h0000_0A0A, 0, 32'h0));
      n0 = last_acc_cyc;
      send(mk(1'b1, 32'h8400_0200, 32'h0000_0B0B, 0, 32'h0));
      send(mk(1'b1, 32'h8800_0300, 32'h0000_0C0C, 0, 32'h0));
      drain();
      chk("t5_saw_full", {31'h0, saw_full}, 32'h1);
      chk("t5_nsetup", obs_setup_sel.size(), 3);
      if (obs_setup_sel.size() == 3) begin
         chk("t5_sel0", {29'h0, obs_setup_sel[0]}, 32'h1);
         chk("t5_sel1", {29'h0, obs_setup_sel[1]}, 32'h2);
         chk("t5_sel2", {29'h0, obs_setup_sel[2]}, 32'h4);
      end
      chk("t5_nrsp", obs_rsp_cyc.size(), 3);
      if (obs_rsp_cyc.size() == 3) begin
         chk("t5_rsp0_cyc", obs_rsp_cyc[0], n0 + 4);
         chk("t5_rsp_gap1", obs_rsp_cyc[1] - obs_rsp_cyc[0], 2);
         chk("t5_rsp_gap2", obs_rsp_cyc[2] - obs_rsp_cyc[1], 2);
      end

      // map boundaries, valid and invalid interleaved
      clear_obs();
      send(mk(1'b1, 32'h83FF_FFFC, 32'h0000_0001, 0, 32'h0));
      send(mk(1'b0, 32'h8C00_0000, 32'h0, 0, 32'h0));
      send(mk(1'b0, 32'h8400_0000, 32'h0, 1, 32'h0BAD_CAFE));
      send(mk(1'b1, 32'h7FFF_FFFC, 32'h0000_0002, 0, 32'h0));
      drain();
      chk("t6_nrsp", obs_rsp_err.size(), 4);
      if (obs_rsp_err.size() == 4) begin
         chk("t6_err0", {31'h0, obs_rsp_err[0]}, 32'h0);
         chk("t6_err1", {31'h0, obs_rsp_err[1]}, 32'h1);
         chk("t6_err2", {31'h0, obs_rsp_err[2]}, 32'h0);
         chk("t6_rd2",  obs_rsp_rdata[2], 32'h0BAD_CAFE);
         chk("t6_err3", {31'h0, obs_rsp_err[3]}, 32'h1);
      end

      // reset during ACCESS with a second request queued
      clear_obs();
      send(mk(1'b1, 32'h8800_0020, 32'hA5A5_0001, 50, 32'h0));
      send(mk(1'b0, 32'h8000_0040, 32'h0, 0, 32'h1111_2222));
      n = 0;
      while (!(m_active && cyc > m_start + 2) && n < 20) begin
         idle();
         n++;
      end
      if (n >= 20) bound_fail("reach_access");
      chk("pre_rst_Pselx",   {29'h0, Pselx},   32'h4);
      chk("pre_rst_Penable", {31'h0, Penable}, 32'h1);
      #2;
      Hreset = 1'b1;
      #1;
      chk("arst_Pselx",     {29'h0, Pselx},     32'h0);
      chk("arst_Penable",   {31'h0, Penable},   32'h0);
      chk("arst_rsp_valid", {31'h0, rsp_valid}, 32'h0);
      chk("arst_busy",      {31'h0, busy},      32'h0);
      chk("arst_req_ready", {31'h0, req_ready}, 32'h1);
      repeat (2) @(posedge Hclk);
      @(negedge Hclk);
      chk("arst_rsp_hold", {31'h0, rsp_valid}, 32'h0);
      Hreset = 1'b0;
      model_reset();
      @(posedge Hclk);
      #1;
      repeat (4) idle();

      // recovery: read with one wait state on slave 2
      clear_obs();
      send(mk(1'b0, 32'h8800_0100, 32'h0, 1, 32'hCAFE_F00D));
      drain();
      chk("t8_nrsp", obs_rsp_rdata.size(), 1);
      if (obs_rsp_rdata.size() > 0) begin
         chk("t8_rsp_rdata", obs_rsp_rdata[0], 32'hCAFE_F00D);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
